dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving the datapath's load/store port: address from ALUResult, store data from WriteData, load data returned as ReadData.
- Adds a request/ready handshake with a configurable fixed latency, so the core can be stalled on memory.
- Provides word and byte access, a word-addressed RAM array, and a small MMIO region: cycle counter and LED register.
- Sits between the core's memory port and the top level.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words; RAM occupies byte addresses 0 to DEPTH_WORDS*4-1.
- LATENCY, 1, cycles from accepted request to ready pulse; legal range 1..15.
- MMIO_BASE, 32'hFFFF_FF00, byte address of the first MMIO register.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- req  input  1  access request; sampled only while able to accept
- we  input  1  1 = store, 0 = load
- byte_en  input  1  1 = byte access (STRB/LDRB/LDRSB), 0 = word
- addr  input  32  byte address (ALUResult)
- wdata  input  32  store data (WriteData); byte stores use wdata[7:0]
- ready  output  1  one-cycle pulse: access complete
- rdata  output  32  load data (ReadData); valid with ready, held until next ready
- err  output  1  qualified by ready: access was illegal
- leds  output  8  LED register contents

Behaviour:
- All outputs are registered.
- Reset values: ready=0, rdata=0, err=0, leds=0, cycle counter=0, FSM=IDLE. RAM contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if req=1, latch addr/we/byte_en/wdata and load the wait counter with LATENCY-1.
  - LATENCY=1: go directly to RESP.
  - Otherwise: go to BUSY.
- BUSY: decrement the wait counter; at 1 go to RESP. req is ignored while in BUSY.
- Timing: ready=1 exactly LATENCY cycles after the accepting edge (req at cycle N → ready high in cycle N+LATENCY).
- RESP: ready=1 for one cycle. In this cycle req=1 is accepted exactly as in IDLE (back-to-back throughput of one access per LATENCY cycles); otherwise return to IDLE.
- Effects commit on the edge that raises ready: the store is written, and rdata/err are loaded.
- Address decode, in priority order:
  - addr < DEPTH_WORDS*4: RAM.
  - addr == MMIO_BASE: cycle counter.
  - addr == MMIO_BASE+4: LED register.
  - Anything else: err.
- Word access with addr[1:0] != 0: err=1, rdata=0, no write.
- Byte store to RAM: write only lane addr[1:0] (little-endian, lane 0 = bits 7:0); other lanes unchanged.
- Byte load from RAM: rdata = {24'b0, selected lane}. Sign extension is the datapath's job.
- Cycle counter: 32-bit, increments every clock, wraps 0xFFFFFFFF → 0.
  - Word load returns its value at the commit edge.
  - Word store loads it with wdata; it increments from that value on the next edge.
  - Byte access to the counter: err.
- LED register:
  - Word store writes wdata[7:0].
  - Byte store to MMIO_BASE+4 writes wdata[7:0].
  - Loads return {24'b0, leds}.
  - Byte access to MMIO_BASE+5..7: err.
- Every err response returns rdata=0 and changes no state.
- Reset mid-operation: FSM returns to IDLE and any pending store is discarded, i.e. never written.

Optional Feature:
- DMEM_CYCLE_CNT_EN
- Defined: cycle counter is present as described above.
- Undefined: no counter register is built. Access to MMIO_BASE returns err=1 and rdata=0. All other behaviour is unchanged.

Test Plan:
- LATENCY=1, reset, then store word 0xDEADBEEF to 0x10, then load 0x10 → ready one cycle after each req; load returns rdata=0xDEADBEEF, err=0.
- After the word above, byte store 0x5A to 0x12, load 0x10 → 0xDE5ABEEF. Byte load 0x13 → 0x000000DE.
- LATENCY=3, req held high continuously → ready pulses every 3 cycles. A req pulsed during BUSY is not accepted.
- Word load 0x11 → err=1, rdata=0. Store to 0x1000 (DEPTH_WORDS=64) → err=1, RAM unchanged.
- Store 0x000000A5 to MMIO_BASE+4 → leds=0xA5. Store 100 to MMIO_BASE, then load it 5 cycles later → value consistent with the increment count. With DMEM_CYCLE_CNT_EN undefined → err=1.
- LATENCY=4, store to 0x20 accepted, reset asserted two cycles later → ready never pulses, leds=0. A subsequent load of 0x20 returns its prior value.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store port between the core and the data-memory responder.
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic        byte_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic [7:0]  leds;

  modport master (output req, we, byte_en, addr, wdata,
                  input  ready, rdata, err, leds);
  modport slave  (input  req, we, byte_en, addr, wdata,
                  output ready, rdata, err, leds);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus cycle-counter/LED MMIO behind a fixed-latency req/ready handshake.
// Optional: define DMEM_CYCLE_CNT_EN to build the cycle counter at MMIO_BASE.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input logic            clk,
  input logic            reset,
  dmem_responder_if.slave bus
);
  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_wait;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_we, r_byte, r_ready, r_err;
  logic [7:0]  r_leds;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept, w_commit;
  logic [31:0] w_addr, w_wdata;
  logic        w_we, w_byte;
  logic        w_ram_hit, w_cnt_hit, w_led_hit, w_err;
  logic [AW-1:0] w_idx;
  logic [31:0] w_rd_word, w_wr_word, w_load_val;
  logic [7:0]  w_lane;

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_RESP)) && bus.req;
  // With single-cycle latency the access commits on its accepting edge, straight from the bus.
  assign w_commit = !reset && (LATENCY == 1 ? w_accept
                                            : (r_state == S_BUSY && r_wait == 4'd1));

  assign w_addr  = (LATENCY == 1) ? bus.addr    : r_addr;
  assign w_wdata = (LATENCY == 1) ? bus.wdata   : r_wdata;
  assign w_we    = (LATENCY == 1) ? bus.we      : r_we;
  assign w_byte  = (LATENCY == 1) ? bus.byte_en : r_byte;

  assign w_ram_hit = w_addr < RAM_BYTES;
`ifdef DMEM_CYCLE_CNT_EN
  assign w_cnt_hit = !w_ram_hit && (w_addr == MMIO_BASE);
`else
  assign w_cnt_hit = 1'b0;
`endif
  assign w_led_hit = !w_ram_hit && (w_addr == MMIO_BASE + 32'd4);

  assign w_err = (!w_byte && w_addr[1:0] != 2'b00)
              || !(w_ram_hit || w_cnt_hit || w_led_hit)
              || (w_byte && w_cnt_hit);

  assign w_idx     = w_addr[AW+1:2];
  assign w_rd_word = r_mem[w_idx];
  assign w_lane    = w_rd_word[{w_addr[1:0], 3'b000} +: 8];

  always_comb begin
    w_wr_word = w_rd_word;
    if (w_byte) w_wr_word[{w_addr[1:0], 3'b000} +: 8] = w_wdata[7:0];
    else        w_wr_word = w_wdata;
  end

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] r_cycle;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     r_cycle <= '0;
    else if (w_commit && w_we && !w_err && w_cnt_hit) r_cycle <= w_wdata;
    else                                           r_cycle <= r_cycle + 32'd1;
  end
`endif

  always_comb begin
    w_load_val = '0;
    if (w_ram_hit)      w_load_val = w_byte ? {24'b0, w_lane} : w_rd_word;
    else if (w_led_hit) w_load_val = {24'b0, r_leds};
`ifdef DMEM_CYCLE_CNT_EN
    else if (w_cnt_hit) w_load_val = r_cycle;
`endif
  end

  // RAM has no reset; w_commit is already gated by reset so a pending store is dropped.
  always_ff @(posedge clk) begin
    if (w_commit && w_we && !w_err && w_ram_hit) r_mem[w_idx] <= w_wr_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_leds  <= '0;
    end else begin
      r_ready <= w_commit;
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? 32'd0 : w_load_val;
        if (w_we && !w_err && w_led_hit) r_leds <= w_wdata[7:0];
      end
      case (r_state)
        S_IDLE, S_RESP: begin
          if (bus.req) begin
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_we    <= bus.we;
            r_byte  <= bus.byte_en;
            r_wait  <= WAIT_INIT;
            r_state <= (LATENCY == 1) ? S_RESP : S_BUSY;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_wait <= r_wait - 4'd1;
          if (r_wait == 4'd1) r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.rdata = r_rdata;
  assign bus.err   = r_err;
  assign bus.leds  = r_leds;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table-driven single-latency accesses plus multi-cycle latency/reset sequences.
module tb_dmem_responder;
  localparam logic [31:0] MB = 32'hFFFF_FF00;

  logic clk = 1'b0;
  logic rst, rst4;
  always #5 clk = ~clk;

  dmem_responder_if bus1 ();
  dmem_responder_if bus3 ();
  dmem_responder_if bus4 ();

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1), .MMIO_BASE(MB)) dut1 (.clk(clk), .reset(rst),  .bus(bus1));
  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(3), .MMIO_BASE(MB)) dut3 (.clk(clk), .reset(rst),  .bus(bus3));
  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(4), .MMIO_BASE(MB)) dut4 (.clk(clk), .reset(rst4), .bus(bus4));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic        be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [7:0]  exp_leds;
  } vec_t;
  vec_t vt[$];

  // LATENCY=1 access: ready must be high the cycle after req, low the cycle after that.
  task automatic acc1(input logic we, input logic be, input logic [31:0] addr, input logic [31:0] wd,
                      output logic rdy, output logic rdy2, output logic [31:0] rd,
                      output logic er, output logic [7:0] ld);
    @(negedge clk);
    bus1.req = 1'b1; bus1.we = we; bus1.byte_en = be; bus1.addr = addr; bus1.wdata = wd;
    @(negedge clk);
    rdy = bus1.ready; rd = bus1.rdata; er = bus1.err; ld = bus1.leds;
    bus1.req = 1'b0;
    @(negedge clk);
    rdy2 = bus1.ready;
  endtask

  // Multi-cycle access on dut3 (sel=3) or dut4 (sel=4); lat = negedges after accept until ready, -1 on timeout.
  task automatic accn(input int sel, input logic we, input logic be, input logic [31:0] addr,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er);
    lat = -1; rd = '0; er = 1'b0;
    @(negedge clk);
    if (sel == 3) begin
      bus3.req = 1'b1; bus3.we = we; bus3.byte_en = be; bus3.addr = addr; bus3.wdata = wd;
    end else begin
      bus4.req = 1'b1; bus4.we = we; bus4.byte_en = be; bus4.addr = addr; bus4.wdata = wd;
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin bus3.req = 1'b0; bus4.req = 1'b0; end
      if ((sel == 3 && bus3.ready) || (sel == 4 && bus4.ready)) begin
        lat = k;
        rd  = (sel == 3) ? bus3.rdata : bus4.rdata;
        er  = (sel == 3) ? bus3.err   : bus4.err;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic rdy, rdy2, er;
    logic [31:0] rd;
    logic [7:0] ld;
    int lat, seen;
    logic [31:0] exp_cnt;

    bus1.req = 0; bus1.we = 0; bus1.byte_en = 0; bus1.addr = 0; bus1.wdata = 0;
    bus3.req = 0; bus3.we = 0; bus3.byte_en = 0; bus3.addr = 0; bus3.wdata = 0;
    bus4.req = 0; bus4.we = 0; bus4.byte_en = 0; bus4.addr = 0; bus4.wdata = 0;
    rst = 1'b1; rst4 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'b0, bus1.ready}, 32'd0);
    chk("reset_rdata", bus1.rdata, 32'd0);
    chk("reset_err",   {31'b0, bus1.err}, 32'd0);
    chk("reset_leds",  {24'b0, bus1.leds}, 32'd0);
    rst = 1'b0; rst4 = 1'b0;

    vt.push_back('{1, 0, 32'h10,     32'hDEADBEEF, 0, 32'h0,        8'h00});
    vt.push_back('{0, 0, 32'h10,     32'h0,        0, 32'hDEADBEEF, 8'h00});
    vt.push_back('{1, 1, 32'h12,     32'h5A,       0, 32'h0,        8'h00});
    vt.push_back('{0, 0, 32'h10,     32'h0,        0, 32'hDE5ABEEF, 8'h00});
    vt.push_back('{0, 1, 32'h13,     32'h0,        0, 32'h000000DE, 8'h00});
    vt.push_back('{0, 1, 32'h12,     32'h0,        0, 32'h0000005A, 8'h00});
    vt.push_back('{0, 0, 32'h11,     32'h0,        1, 32'h0,        8'h00});
    vt.push_back('{1, 0, 32'h1000,   32'h55555555, 1, 32'h0,        8'h00});
    vt.push_back('{1, 0, 32'h13,     32'h66666666, 1, 32'h0,        8'h00});
    vt.push_back('{0, 0, 32'h10,     32'h0,        0, 32'hDE5ABEEF, 8'h00});
    vt.push_back('{1, 0, 32'hFC,     32'h11223344, 0, 32'h0,        8'h00});
    vt.push_back('{0, 0, 32'hFC,     32'h0,        0, 32'h11223344, 8'h00});
    vt.push_back('{0, 1, 32'hFD,     32'h0,        0, 32'h00000033, 8'h00});
    vt.push_back('{0, 0, 32'h100,    32'h0,        1, 32'h0,        8'h00});
    vt.push_back('{1, 0, MB + 4,     32'h000000A5, 0, 32'h0,        8'hA5});
    vt.push_back('{0, 0, MB + 4,     32'h0,        0, 32'h000000A5, 8'hA5});
    vt.push_back('{1, 1, MB + 5,     32'hFF,       1, 32'h0,        8'hA5});
    vt.push_back('{1, 1, MB + 4,     32'h123C,     0, 32'h0,        8'h3C});
    vt.push_back('{0, 1, MB + 4,     32'h0,        0, 32'h0000003C, 8'h3C});
    vt.push_back('{0, 0, MB + 6,     32'h0,        1, 32'h0,        8'h3C});
    vt.push_back('{0, 1, MB,         32'h0,        1, 32'h0,        8'h3C});
    vt.push_back('{1, 0, MB + 8,     32'h0,        1, 32'h0,        8'h3C});

    foreach (vt[i]) begin
      acc1(vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata, rdy, rdy2, rd, er, ld);
      chk($sformatf("v%0d_ready", i),  {31'b0, rdy},  32'd1);
      chk($sformatf("v%0d_pulse", i),  {31'b0, rdy2}, 32'd0);
      chk($sformatf("v%0d_err", i),    {31'b0, er},   {31'b0, vt[i].exp_err});
      chk($sformatf("v%0d_leds", i),   {24'b0, ld},   {24'b0, vt[i].exp_leds});
      if (!vt[i].we || vt[i].exp_err) chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
    end

    // Counter: store 100, load issued so it commits five edges later -> 104.
    @(negedge clk);
    bus1.req = 1; bus1.we = 1; bus1.byte_en = 0; bus1.addr = MB; bus1.wdata = 32'd100;
    @(negedge clk);
    bus1.req = 0;
`ifdef DMEM_CYCLE_CNT_EN
    chk("cnt_store_err", {31'b0, bus1.err}, 32'd0);
    exp_cnt = 32'd104;
`else
    chk("cnt_store_err", {31'b0, bus1.err}, 32'd1);
    exp_cnt = 32'd0;
`endif
    repeat (4) @(negedge clk);
    bus1.req = 1; bus1.we = 0; bus1.addr = MB;
    @(negedge clk);
    bus1.req = 0;
    chk("cnt_load_ready", {31'b0, bus1.ready}, 32'd1);
    chk("cnt_load_rdata", bus1.rdata, exp_cnt);
`ifdef DMEM_CYCLE_CNT_EN
    chk("cnt_load_err", {31'b0, bus1.err}, 32'd0);
`else
    chk("cnt_load_err", {31'b0, bus1.err}, 32'd1);
`endif

    // LATENCY=3 with req held: ready on every third cycle.
    @(negedge clk);
    bus3.req = 1; bus3.we = 0; bus3.byte_en = 0; bus3.addr = 32'h0;
    @(posedge clk);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("l3_hold_k%0d", k), {31'b0, bus3.ready}, {31'b0, (k % 3) == 2});
    end
    bus3.req = 0;
    repeat (4) @(negedge clk);

    accn(3, 1, 0, 32'h44, 32'h11, lat, rd, er);
    chk("l3_pre44_lat", lat, 32'd2);
    // Store to 0x40, then a req pulse while BUSY that must be dropped.
    @(negedge clk);
    bus3.req = 1; bus3.we = 1; bus3.byte_en = 0; bus3.addr = 32'h40; bus3.wdata = 32'h77;
    @(negedge clk);
    bus3.addr = 32'h44; bus3.wdata = 32'h99;
    @(negedge clk);
    bus3.req = 0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus3.ready) seen++;
      @(negedge clk);
    end
    chk("l3_busy_ready_count", seen, 32'd1);
    accn(3, 0, 0, 32'h40, 32'h0, lat, rd, er);
    chk("l3_ld40_lat", lat, 32'd2);
    chk("l3_ld40_rdata", rd, 32'h77);
    accn(3, 0, 0, 32'h44, 32'h0, lat, rd, er);
    chk("l3_ld44_rdata", rd, 32'h11);
    chk("l3_ld44_err", {31'b0, er}, 32'd0);

    // LATENCY=4: reset two cycles after accept drops the pending store.
    accn(4, 1, 0, 32'h20, 32'h12345678, lat, rd, er);
    chk("l4_pre_lat", lat, 32'd3);
    @(negedge clk);
    bus4.req = 1; bus4.we = 1; bus4.byte_en = 0; bus4.addr = 32'h20; bus4.wdata = 32'hCAFEF00D;
    @(posedge clk);
    seen = 0;
    @(negedge clk);
    bus4.req = 0;
    if (bus4.ready) seen++;
    @(negedge clk);
    if (bus4.ready) seen++;
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus4.ready) seen++;
    end
    chk("l4_rst_no_ready", seen, 32'd0);
    chk("l4_rst_leds", {24'b0, bus4.leds}, 32'd0);
    accn(4, 0, 0, 32'h20, 32'h0, lat, rd, er);
    chk("l4_post_lat", lat, 32'd3);
    chk("l4_post_rdata", rd, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
